// File: rtl/cvp_pkg.sv
// Shared CVP definitions: ISA opcodes, vector memory sequencer state encoding and
// default datapath geometry.
package cvp_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OpAdd  = 4'b0000;
    localparam opcode_t OpSub  = 4'b0001;
    localparam opcode_t OpAnd  = 4'b0010;
    localparam opcode_t OpOr   = 4'b0011;
    localparam opcode_t OpVld  = 4'b0100;
    localparam opcode_t OpVst  = 4'b0101;
    localparam opcode_t OpJmp  = 4'b0110;
    localparam opcode_t OpHalt = 4'b0111;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StDrain = 3'd2,
        StStore = 3'd3,
        StDone  = 3'd4
    } seq_state_e;

    localparam int unsigned DefLanes = 16;
    localparam int unsigned DefDw    = 16;
    localparam int unsigned DefAw    = 16;

endpackage

// File: rtl/vec_mem_seq_if.sv
// Word-addressed memory port of the vector load/store sequencer.
// Read data returns the cycle after the read strobe.
interface vec_mem_seq_if import cvp_pkg::*; #(
    parameter int unsigned AW = DefAw,
    parameter int unsigned DW = DefDw
) ();

    logic [AW-1:0] Addr;
    logic          RD;
    logic          WR;
    logic [DW-1:0] DataOut;
    logic [DW-1:0] DataIn;

    modport master (
        output Addr,
        output RD,
        output WR,
        output DataOut,
        input  DataIn
    );

    modport slave (
        input  Addr,
        input  RD,
        input  WR,
        input  DataOut,
        output DataIn
    );

endinterface

// File: rtl/vec_addr_gen.sv
// Strided address generator: running base + k*stride accumulator with a sticky
// carry flag that records any wrap past 2^AW.
module vec_addr_gen import cvp_pkg::*; #(
    parameter int unsigned AW = DefAw
) (
    input  logic          Clk1,
    input  logic          Reset,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] stride,
    output logic [AW-1:0] addr,
    output logic          wrapped
);

    logic [AW-1:0] addr_q;
    logic [AW-1:0] stride_q;
    logic          wrapped_q;
    logic [AW:0]   sum;

    assign sum = {1'b0, addr_q} + {1'b0, stride_q};

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            addr_q    <= '0;
            stride_q  <= '0;
            wrapped_q <= 1'b0;
        end else if (load) begin
            addr_q    <= base;
            stride_q  <= stride;
            wrapped_q <= 1'b0;
        end else if (step) begin
            addr_q    <= sum[AW-1:0];
            wrapped_q <= wrapped_q | sum[AW];
        end
    end

    assign addr    = addr_q;
    assign wrapped = wrapped_q;

endmodule

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer: streams LANES elements between a vector image and
// memory at base + k*stride, one access per cycle, with completion and wrap flags.
module vec_mem_seq import cvp_pkg::*; #(
    parameter int unsigned LANES = DefLanes,
    parameter int unsigned DW    = DefDw,
    parameter int unsigned AW    = DefAw
) (
    input  logic                Clk1,
    input  logic                Reset,
    input  logic                start,
    input  logic                op,
    input  logic [AW-1:0]       base,
    input  logic [AW-1:0]       stride,
    input  logic [LANES*DW-1:0] vIn,
    output logic [LANES*DW-1:0] vOut,
    output logic                busy,
    output logic                done,
    output logic                V,
    vec_mem_seq_if.master       mem
);

    localparam int unsigned KW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [KW-1:0] LastK = KW'(LANES - 1);

    seq_state_e state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [LANES*DW-1:0] vin_q;
    logic accept;
    logic ag_step;
    logic [AW-1:0] ag_addr;
    logic ag_wrapped;

    logic rd_q, wr_q, done_q, busy_q, v_q, rvalid_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [KW-1:0] rlane_q;
    logic [LANES*DW-1:0] vout_q;

    vec_addr_gen #(
        .AW (AW)
    ) u_addr_gen (
        .Clk1    (Clk1),
        .Reset   (Reset),
        .load    (accept),
        .step    (ag_step),
        .base    (base),
        .stride  (stride),
        .addr    (ag_addr),
        .wrapped (ag_wrapped)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        accept  = 1'b0;
        ag_step = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    k_d     = '0;
                    state_d = op ? StStore : StLoad;
                end
            end
            StLoad, StStore: begin
                if (k_q == LastK) begin
                    k_d     = '0;
                    state_d = (state_q == StLoad) ? StDrain : StDone;
                end else begin
                    k_d     = k_q + 1'b1;
                    ag_step = 1'b1;
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state_q <= StIdle;
            k_q     <= '0;
            vin_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (accept) begin
                vin_q <= vIn;
            end
        end
    end

    // Strobes trail the FSM state by one register stage; read data is captured
    // one cycle after each strobe, independent of the state it lands in.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            v_q      <= 1'b0;
            rvalid_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rlane_q  <= '0;
            vout_q   <= '0;
        end else begin
            rd_q     <= (state_q == StLoad);
            wr_q     <= (state_q == StStore);
            done_q   <= (state_q == StDone);
            busy_q   <= accept | (busy_q & ~done_q);
            v_q      <= accept ? 1'b0 : ag_wrapped;
            rvalid_q <= rd_q;
            if (state_q == StLoad || state_q == StStore) begin
                addr_q <= ag_addr;
            end
            wdata_q <= (state_q == StStore) ? vin_q[k_q*DW +: DW] : '0;
            if (accept) begin
                rlane_q <= '0;
            end else if (rvalid_q) begin
                vout_q[rlane_q*DW +: DW] <= mem.DataIn;
                rlane_q                  <= rlane_q + 1'b1;
            end
        end
    end

    assign mem.Addr    = addr_q;
    assign mem.RD      = rd_q;
    assign mem.WR      = wr_q;
    assign mem.DataOut = wdata_q;
    assign vOut        = vout_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign V           = v_q;

endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed bench for vec_mem_seq with LANES=4, DW=AW=16 and a one-cycle-latency
// memory model.
module tb_vec_mem_seq;

    logic        Clk1;
    logic        Reset;
    logic        start;
    logic        op;
    logic [15:0] base;
    logic [15:0] stride;
    logic [63:0] vIn;
    logic [63:0] vOut;
    logic        busy;
    logic        done;
    logic        V;

    vec_mem_seq_if #(.AW(16), .DW(16)) mem_bus ();

    vec_mem_seq #(
        .LANES (4),
        .DW    (16),
        .AW    (16)
    ) dut (
        .Clk1   (Clk1),
        .Reset  (Reset),
        .start  (start),
        .op     (op),
        .base   (base),
        .stride (stride),
        .vIn    (vIn),
        .vOut   (vOut),
        .busy   (busy),
        .done   (done),
        .V      (V),
        .mem    (mem_bus)
    );

    initial Clk1 = 1'b0;
    always #5 Clk1 = ~Clk1;

    int n_vec = 0;
    int n_mis = 0;
    int edge_cnt = 0;
    int n_done = 0;
    int done_edge = 0;
    int overlap = 0;
    logic v_at_done = 1'b0;
    logic [15:0] rd_log [$];
    logic [15:0] wa_log [$];
    logic [15:0] wd_log [$];

    logic [15:0] memory [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [15:0] pl_data = '0;

    always @(posedge Clk1) begin
        edge_cnt <= edge_cnt + 1;
        if (mem_bus.RD) mem_bus.DataIn <= memory[mem_bus.Addr];
        if (mem_bus.WR) memory[mem_bus.Addr] <= mem_bus.DataOut;
        if (pl_en) memory[pl_addr] <= pl_data;
    end

    always @(negedge Clk1) begin
        if (mem_bus.RD) rd_log.push_back(mem_bus.Addr);
        if (mem_bus.WR) begin
            wa_log.push_back(mem_bus.Addr);
            wd_log.push_back(mem_bus.DataOut);
        end
        if (mem_bus.RD && mem_bus.WR) overlap = overlap + 1;
        if (done) begin
            n_done    = n_done + 1;
            done_edge = edge_cnt;
            v_at_done = V;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [15:0] q[$], input int first,
                        input logic [15:0] e0, input logic [15:0] e1,
                        input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({tag, "_count"}, 64'(q.size() - first), 64'd4);
        if (q.size() - first == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("%s[%0d]", tag, i), q[first+i], e[i]);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge Clk1); #1;
        pl_en = 1'b0;
    endtask

    // Issues one request; optionally re-pulses start mid-operation at cycle 'intrude'.
    task automatic run_op(input logic o, input logic [15:0] b, input logic [15:0] s,
                          input logic [63:0] vi, input int intrude, output int lat,
                          output int rd0, output int wr0);
        int s_edge;
        int dn0;
        rd0 = rd_log.size(); wr0 = wa_log.size(); dn0 = n_done;
        op = o; base = b; stride = s; vIn = vi; start = 1'b1;
        @(posedge Clk1); #1;
        s_edge = edge_cnt;
        start = 1'b0; vIn = ~vi; base = 16'hdead; stride = 16'h0007;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("v_clear_at_start", 64'(V), 64'd0);
        lat = -1;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            @(negedge Clk1); #1;
            if (i == intrude) begin
                start = 1'b1; op = ~o; base = 16'h0200;
            end else begin
                start = 1'b0;
            end
            if (n_done != dn0) lat = done_edge - s_edge;
        end
        start = 1'b0;
        chk("done_seen", 64'(lat >= 0), 64'd1);
        @(posedge Clk1); #1;
        chk("busy_dropped", 64'(busy), 64'd0);
        chk("single_done", 64'(n_done - dn0), 64'd1);
    endtask

    int lat, rd0, wr0;

    initial begin
        Reset = 1'b1; start = 1'b0; op = 1'b0; base = '0; stride = '0; vIn = '0;
        repeat (2) @(posedge Clk1);
        #1;
        chk("rst_vout", vOut, 64'd0);
        chk("rst_addr", 64'(mem_bus.Addr), 64'd0);
        chk("rst_strobes", {62'd0, mem_bus.RD, mem_bus.WR}, 64'd0);
        chk("rst_flags", {61'd0, busy, done, V}, 64'd0);
        chk("rst_dataout", 64'(mem_bus.DataOut), 64'd0);
        Reset = 1'b0;

        preload(16'h0010, 16'h00A0); preload(16'h0011, 16'h00A1);
        preload(16'h0012, 16'h00A2); preload(16'h0013, 16'h00A3);
        preload(16'hFFFE, 16'h0BEE); preload(16'hFFFF, 16'h0BEF);
        preload(16'h0000, 16'h0C00); preload(16'h0001, 16'h0C01);

        // Plain load
        run_op(1'b0, 16'h0010, 16'h0001, 64'd0, -1, lat, rd0, wr0);
        chk("t1_latency", 64'(lat), 64'd6);
        chk4("t1_rd_addr", rd_log, rd0, 16'h0010, 16'h0011, 16'h0012, 16'h0013);
        chk("t1_no_wr", 64'(wa_log.size() - wr0), 64'd0);
        chk("t1_vout", vOut, 64'h00A3_00A2_00A1_00A0);
        chk("t1_v", 64'(V), 64'd0);

        // Strided store
        run_op(1'b1, 16'h0100, 16'h0002, 64'h4444_3333_2222_1111, -1, lat, rd0, wr0);
        chk("t2_latency", 64'(lat), 64'd5);
        chk("t2_no_rd", 64'(rd_log.size() - rd0), 64'd0);
        chk4("t2_wr_addr", wa_log, wr0, 16'h0100, 16'h0102, 16'h0104, 16'h0106);
        chk4("t2_wr_data", wd_log, wr0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        chk("t2_mem104", 64'(memory[16'h0104]), 64'h3333);
        chk("t2_vout_held", vOut, 64'h00A3_00A2_00A1_00A0);

        // Address wrap
        run_op(1'b0, 16'hFFFE, 16'h0001, 64'd0, -1, lat, rd0, wr0);
        chk("t3_latency", 64'(lat), 64'd6);
        chk4("t3_rd_addr", rd_log, rd0, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001);
        chk("t3_vout", vOut, 64'h0C01_0C00_0BEF_0BEE);
        chk("t3_v_at_done", 64'(v_at_done), 64'd1);
        chk("t3_v_held", 64'(V), 64'd1);

        // Start while busy is ignored
        run_op(1'b0, 16'h0010, 16'h0001, 64'd0, 1, lat, rd0, wr0);
        chk("t4_latency", 64'(lat), 64'd6);
        chk4("t4_rd_addr", rd_log, rd0, 16'h0010, 16'h0011, 16'h0012, 16'h0013);
        chk("t4_no_wr", 64'(wa_log.size() - wr0), 64'd0);
        chk("t4_vout", vOut, 64'h00A3_00A2_00A1_00A0);

        // Reset during LOAD k=2
        op = 1'b0; base = 16'h0010; stride = 16'h0001; start = 1'b1;
        @(posedge Clk1); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge Clk1); #1;
        end
        Reset = 1'b1;
        @(posedge Clk1); #1;
        Reset = 1'b0;
        chk("t5_rd", 64'(mem_bus.RD), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_vout", vOut, 64'd0);
        repeat (3) begin
            @(posedge Clk1); #1;
        end
        chk("t5_vout_settled", vOut, 64'd0);
        chk("t5_idle_rd", 64'(mem_bus.RD), 64'd0);
        run_op(1'b1, 16'h0040, 16'h0003, 64'h000D_000C_000B_000A, -1, lat, rd0, wr0);
        chk("t5_latency", 64'(lat), 64'd5);
        chk4("t5_wr_addr", wa_log, wr0, 16'h0040, 16'h0043, 16'h0046, 16'h0049);
        chk4("t5_wr_data", wd_log, wr0, 16'h000A, 16'h000B, 16'h000C, 16'h000D);

        // Zero stride store
        run_op(1'b1, 16'h0300, 16'h0000, 64'h0404_0303_0202_0101, -1, lat, rd0, wr0);
        chk("t6_latency", 64'(lat), 64'd5);
        chk4("t6_wr_addr", wa_log, wr0, 16'h0300, 16'h0300, 16'h0300, 16'h0300);
        chk4("t6_wr_data", wd_log, wr0, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
        chk("t6_v", 64'(V), 64'd0);
        chk("t6_mem300", 64'(memory[16'h0300]), 64'h0404);

        chk("no_rd_wr_overlap", 64'(overlap), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
